// File: rtl/regfile_port_master.sv
// Register-file port master: operand fetch with writeback bypass,
// plus a small writeback FIFO that drains one write per cycle.
module regfile_port_master #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int WB_DEPTH = 4,
  parameter int TAG_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_a,
  output logic [DATA_W-1:0] rsp_b,
  output logic [TAG_W-1:0]  rsp_tag,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_r1,
  output logic [ADDR_W-1:0] rf_r2,
  output logic [ADDR_W-1:0] rf_w,
  output logic [DATA_W-1:0] rf_wD,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rD1,
  input  logic [DATA_W-1:0] rf_rD2,
  output logic              wb_empty
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_fa [WB_DEPTH];
  logic [DATA_W-1:0] r_fd [WB_DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_a;
  logic [DATA_W-1:0] r_rsp_b;
  logic [TAG_W-1:0]  r_rsp_tag;

  logic              w_wb_fire;
  logic              w_req_fire;
  logic              w_pop;
  logic [DATA_W-1:0] w_byp_a;
  logic [DATA_W-1:0] w_byp_b;

  assign rf_r1      = req_rs1;
  assign rf_r2      = req_rs2;
  assign req_ready  = !r_rsp_valid | rsp_ready;
  assign w_req_fire = req_valid & req_ready;
  assign wb_ready   = (r_count != CW'(WB_DEPTH));
  assign w_wb_fire  = wb_valid & wb_ready;
  assign wb_empty   = (r_count == '0);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_a      = r_rsp_a;
  assign rsp_b      = r_rsp_b;
  assign rsp_tag    = r_rsp_tag;

  // Next-state and register-file write port; one pop per DRAIN cycle
  always_comb begin
    w_pop       = 1'b0;
    rf_we       = 1'b0;
    rf_w        = '0;
    rf_wD       = '0;
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        w_pop = 1'b0;
      end
      S_DRAIN: begin
        w_pop = 1'b1;
        rf_we = 1'b1;
        rf_w  = r_fa[r_rd_ptr];
        rf_wD = r_fd[r_rd_ptr];
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
    w_count_nxt = r_count + CW'(w_wb_fire) - CW'(w_pop);
    w_state_nxt = (w_count_nxt != '0) ? S_DRAIN : S_IDLE;
  end

  // Newest value per operand: same-cycle writeback, then youngest FIFO entry
  always_comb begin
    logic [PW-1:0] v_idx;
    w_byp_a = rf_rD1;
    w_byp_b = rf_rD2;
    v_idx   = r_rd_ptr;
    for (int i = 0; i < WB_DEPTH; i++) begin
      v_idx = r_rd_ptr + PW'(i);
      if (CW'(i) < r_count) begin
        if (r_fa[v_idx] == req_rs1) w_byp_a = r_fd[v_idx];
        if (r_fa[v_idx] == req_rs2) w_byp_b = r_fd[v_idx];
      end
    end
    if (w_wb_fire && (wb_addr == req_rs1)) w_byp_a = wb_data;
    if (w_wb_fire && (wb_addr == req_rs2)) w_byp_b = wb_data;
  end

  // Drain FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Writeback FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        r_fa[i] <= '0;
        r_fd[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (w_wb_fire) begin
        r_fa[r_wr_ptr] <= wb_addr;
        r_fd[r_wr_ptr] <= wb_data;
        r_wr_ptr       <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Operand response register, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_a     <= '0;
      r_rsp_b     <= '0;
      r_rsp_tag   <= '0;
    end else if (w_req_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_a     <= w_byp_a;
      r_rsp_b     <= w_byp_b;
      r_rsp_tag   <= req_tag;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_port_master.sv
// Bench for regfile_port_master: directed table, hand sequences,
// and random traffic against an architectural register model.
module tb_regfile_port_master;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int WD = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_rs1, req_rs2;
  logic [TW-1:0] req_tag;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_a, rsp_b;
  logic [TW-1:0] rsp_tag;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rf_r1, rf_r2, rf_w;
  logic [DW-1:0] rf_wD, rf_rD1, rf_rD2;
  logic          rf_we, wb_empty;

  regfile_port_master #(
    .DATA_W(DW), .ADDR_W(AW), .WB_DEPTH(WD), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_tag(rsp_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_w(rf_w),
    .rf_wD(rf_wD), .rf_we(rf_we),
    .rf_rD1(rf_rD1), .rf_rD2(rf_rD2),
    .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  // register file attached to the ports
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) if (rf_we) rf_mem[rf_w] <= rf_wD;
  assign rf_rD1 = rf_mem[rf_r1];
  assign rf_rD2 = rf_mem[rf_r2];

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [63:0] got,
                              logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  // architectural model: newest accepted value per register,
  // pending writes in acceptance order, outstanding response
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [TW-1:0] t; logic [DW-1:0] a, b; } rs_t;
  logic [DW-1:0] arch [32];
  wr_t wq [$];
  rs_t rq [$];

  always @(negedge rst_n) begin
    wq.delete();
    rq.delete();
    for (int i = 0; i < 32; i++) arch[i] = rf_mem[i];
  end

  always @(negedge clk) begin : mon
    logic wbf, rdy, rqf;
    rs_t  r;
    if (rst_n === 1'b1) begin
      chk("rf_we", rf_we, wq.size() != 0);
      if (rf_we && wq.size() != 0) begin
        chk("rf_w", rf_w, wq[0].a);
        chk("rf_wD", rf_wD, wq[0].d);
      end
      chk("wb_ready", wb_ready, wq.size() != WD);
      chk("wb_empty", wb_empty, wq.size() == 0);
      chk("rsp_valid", rsp_valid, rq.size() != 0);
      rdy = (rq.size() == 0) || rsp_ready;
      chk("req_ready", req_ready, rdy);
      chk("rf_r1", rf_r1, req_rs1);
      chk("rf_r2", rf_r2, req_rs2);
      if (rsp_valid && rq.size() != 0) begin
        chk("rsp_tag", rsp_tag, rq[0].t);
        chk("rsp_a", rsp_a, rq[0].a);
        chk("rsp_b", rsp_b, rq[0].b);
      end
      wbf = wb_valid && (wq.size() != WD);
      rqf = req_valid && rdy;
      if (wq.size() != 0) void'(wq.pop_front());
      if (wbf) begin
        wq.push_back('{a: wb_addr, d: wb_data});
        arch[wb_addr] = wb_data;
      end
      if (rsp_ready && rq.size() != 0) void'(rq.pop_front());
      if (rqf) begin
        r.t = req_tag;
        r.a = arch[req_rs1];
        r.b = arch[req_rs2];
        rq.push_back(r);
      end
    end
  end

  typedef struct {
    bit            wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            rv;
    logic [AW-1:0] r1, r2;
    logic [TW-1:0] tg;
    logic [DW-1:0] ea, eb;
  } vec_t;

  vec_t tbl [14];

  task automatic idle_in();
    req_valid = 0; req_rs1 = 0; req_rs2 = 0; req_tag = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; rsp_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = '0;
      arch[i] = '0;
    end
    tbl[0]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[3]  = '{1, 1, 32'hF0F0F0F0, 1, 1, 0, 2,
                32'hF0F0F0F0, 32'hFFFFFFFF};
    tbl[4]  = '{1, 7, 32'hA, 1, 7, 1, 6, 32'hA, 32'hF0F0F0F0};
    tbl[5]  = '{1, 7, 32'hB, 1, 7, 7, 7, 32'hB, 32'hB};
    tbl[6]  = '{0, 0, 0, 1, 7, 7, 8, 32'hB, 32'hB};
    tbl[7]  = '{0, 0, 0, 1, 7, 0, 9, 32'hB, 32'hFFFFFFFF};
    tbl[8]  = '{1, 2, 32'd1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 2, 32'd2, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 2, 32'd3, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 2, 32'd4, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 2, 32'd5, 1, 2, 1, 10, 32'd5, 32'hF0F0F0F0};
    tbl[13] = '{0, 0, 0, 1, 2, 2, 11, 32'd5, 32'd5};

    rst_n = 0;
    idle_in();
    tick();
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_a", rsp_a, 0);
    chk("rst_rsp_b", rsp_b, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_wb_empty", wb_empty, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_w", rf_w, 0);
    chk("rst_rf_wD", rf_wD, 0);
    rst_n = 1;
    tick();

    // directed table, one row per cycle, response checked next cycle
    for (int i = 0; i < 14; i++) begin
      wb_valid = tbl[i].wv; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
      req_valid = tbl[i].rv; req_rs1 = tbl[i].r1;
      req_rs2 = tbl[i].r2; req_tag = tbl[i].tg;
      rsp_ready = 1;
      tick();
      chk($sformatf("tbl%0d_valid", i), rsp_valid, tbl[i].rv);
      if (tbl[i].rv) begin
        chk($sformatf("tbl%0d_a", i), rsp_a, tbl[i].ea);
        chk($sformatf("tbl%0d_b", i), rsp_b, tbl[i].eb);
        chk($sformatf("tbl%0d_tag", i), rsp_tag, tbl[i].tg);
      end
    end
    idle_in();
    repeat (3) tick();
    chk("rf2_final", rf_mem[2], 5);
    chk("rf7_final", rf_mem[7], 32'hB);

    // response backpressure: tag 3 held, tag 4 waits
    req_valid = 1; req_rs1 = 1; req_rs2 = 2; req_tag = 3;
    tick();
    rsp_ready = 0; req_tag = 4; req_rs1 = 0; req_rs2 = 7;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_ready", req_ready, 0);
      tick();
      chk("bp_tag_hold", rsp_tag, 3);
      chk("bp_a_hold", rsp_a, 32'hF0F0F0F0);
    end
    rsp_ready = 1;
    #1;
    chk("bp_release_ready", req_ready, 1);
    tick();
    chk("bp_tag4", rsp_tag, 4);
    chk("bp_tag4_b", rsp_b, 32'hB);
    req_valid = 0;
    tick();
    chk("bp_drained", rsp_valid, 0);

    // reset while a writeback is being drained
    wb_valid = 1; wb_addr = 3; wb_data = 32'h33;
    tick();
    wb_valid = 0;
    #1;
    chk("pre_rst_we", rf_we, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_empty", wb_empty, 1);
    tick();
    tick();
    rst_n = 1;
    repeat (3) tick();
    chk("rst_lost_write", rf_mem[3], 0);
    req_valid = 1; req_rs1 = 3; req_rs2 = 0; req_tag = 5;
    tick();
    chk("rst_read3", rsp_a, 0);
    idle_in();
    tick();

    // random traffic over a few hot registers
    for (int i = 0; i < 600; i++) begin
      wb_valid  = $urandom_range(0, 1);
      wb_addr   = AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      req_valid = $urandom_range(0, 1);
      req_rs1   = AW'($urandom_range(0, 7));
      req_rs2   = AW'($urandom_range(0, 7));
      req_tag   = TW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_in();
    repeat (4) tick();
    chk("end_empty", wb_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
